multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 8: maximum cycles spent in MEM waiting for mem_ready before trapping.
REQ-002 Parameter CNT_W, default 32: width of the retire counter.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port Opcode, input, 7: instruction bits [6:0].
REQ-006 Port Funct, input, 4: {instr[30], instr[14:12]}.
REQ-007 Port mem_ready, input, 1: data memory completion strobe.
REQ-008 Ports IRWrite, PCWrite, Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite: outputs, 1 bit each, datapath strobes.
REQ-009 Port Operation, output, 4: ALU operation select.
REQ-010 Port state, output, 3: current FSM state code.
REQ-011 Port illegal, output, 1: sticky trap flag.

Function
REQ-012 The states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5, with codes 6 and 7 returning to FETCH on the next edge.
REQ-013 FETCH SHALL assert IRWrite and go to DECODE after exactly 1 cycle.
REQ-014 DECODE SHALL latch Opcode and Funct into internal registers; all later states SHALL decode only the latched copies.
REQ-015 DECODE SHALL go to EXEC for these opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch).
REQ-016 DECODE SHALL go to TRAP for any other opcode.
REQ-017 EXEC SHALL then go: R or I-ALU -> WB; load or store -> MEM; branch -> FETCH.
REQ-018 EXEC SHALL assert ALUSrc for I-ALU, load and store.
REQ-019 EXEC SHALL assert Branch and PCWrite for a branch.
REQ-020 MEM SHALL assert MemRead for a load or MemWrite for a store, holding it every cycle until the cycle in which mem_ready=1.
REQ-021 On mem_ready=1 in MEM, a load SHALL go to WB and a store SHALL go to FETCH with PCWrite=1 in that cycle.
REQ-022 The MEM wait counter SHALL clear on MEM entry and increment each cycle mem_ready=0.
REQ-023 When the wait counter reaches MEM_TIMEOUT with mem_ready=0, the FSM SHALL go to TRAP, with no MemRead or MemWrite in the following cycle.
REQ-024 If mem_ready=1 in the same cycle the timeout is reached, completion SHALL take priority over the timeout.
REQ-025 WB SHALL assert RegWrite and PCWrite, assert MemtoReg only for a load, and go to FETCH.
REQ-026 TRAP SHALL hold all strobes at 0 and illegal at 1 until reset; mem_ready and Opcode SHALL be ignored.
REQ-027 Operation SHALL be 0010 (ADD) for load and store.
REQ-028 Operation SHALL be 0110 (SUB) for a branch with Funct[2:0]=000 (beq); any other branch funct3 SHALL go to TRAP from DECODE.
REQ-029 R-type Funct SHALL map 0000->0010, 1000->0110, 0111->0000 (AND), 0110->0001 (OR), 0100->0011 (XOR); any other R-type Funct SHALL go to TRAP from DECODE.
REQ-030 I-ALU SHALL ignore Funct[3] and map funct3 000->0010, 111->0000, 110->0001, 100->0011; any other funct3 SHALL go to TRAP from DECODE.
REQ-031 Operation SHALL be 0000 in FETCH, DECODE and TRAP.
REQ-032 All strobes SHALL be Moore outputs of state plus the latched opcode/funct, except the MEM-exit PCWrite, which depends on mem_ready.

Reset
REQ-033 Asserting reset SHALL immediately, asynchronously and at any point mid-instruction set state=FETCH, the wait counter to 0, the latched opcode/funct to 0, illegal=0, and the retire counter to 0.
REQ-034 While reset is high, every output SHALL be 0, including IRWrite.
REQ-035 On the first edge after reset deassertion, the FSM SHALL be in FETCH.

Configuration
REQ-036 With macro CTRL_RETIRE_CNT_EN defined, the block SHALL add output retired[CNT_W-1:0], which increments on every cycle PCWrite=1, wraps modulo 2^CNT_W, and does not count in TRAP.
REQ-037 Without CTRL_RETIRE_CNT_EN, the retired port and its counter SHALL NOT exist.

Verification
REQ-038 R-type add (0110011/0000) after reset -> states 0,1,2,4,0; Operation=0010 in EXEC; RegWrite=1 and PCWrite=1 in WB only.
REQ-039 Load with mem_ready rising on the 3rd MEM cycle -> MemRead=1 for exactly 3 cycles, then WB with MemtoReg=1 and RegWrite=1.
REQ-040 Store with mem_ready held 0 and MEM_TIMEOUT=8 -> TRAP after 8 MEM cycles, illegal=1; a later mem_ready=1 has no effect.
REQ-041 Opcode 1111111, and separately a branch with funct3=001 -> DECODE to TRAP, all strobes 0.
REQ-042 Reset pulsed in MEM during a store -> MemWrite drops to 0 without waiting for a clock edge; first post-reset state is FETCH.
REQ-043 With CTRL_RETIRE_CNT_EN and CNT_W=4, retire 17 instructions -> retired=1.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//
// Purpose:
//   Control FSM for a multi-cycle RISC-V style datapath. Each instruction goes
//   through FETCH -> DECODE -> EXEC and then, depending on its class, through
//   MEM and/or WB. Unsupported opcodes or funct encodings, and data memory
//   accesses that never complete, park the FSM in TRAP until reset.
//
// Parameters:
//   MEM_TIMEOUT  maximum cycles spent in MEM without mem_ready before trapping
//   CNT_W        width of the optional retire counter
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous active-high reset
//   Opcode     instruction bits [6:0], sampled in DECODE
//   Funct      {instr[30], instr[14:12]}, sampled in DECODE
//   mem_ready  data memory completion strobe
//   IRWrite, PCWrite, Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite
//              datapath strobes
//   Operation  ALU operation select
//   state      current FSM state code
//   retired    retire counter (only with CTRL_RETIRE_CNT_EN)
//   illegal    sticky trap flag
//
// Configuration:
//   CTRL_RETIRE_CNT_EN  when defined, adds the 'retired' output, counting every
//                       cycle with PCWrite=1 modulo 2^CNT_W.

module multicycle_control #(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic [3:0]       Funct,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic [3:0]       Operation,
  output logic [2:0]       state,
`ifdef CTRL_RETIRE_CNT_EN
  output logic [CNT_W-1:0] retired,
`endif
  output logic             illegal
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_RTYPE  = 3'd1,
    C_IALU   = 3'd2,
    C_LOAD   = 3'd3,
    C_STORE  = 3'd4,
    C_BRANCH = 3'd5
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    logic [3:0] aluOp;
    logic       legal;
  } dec_t;

  // Instruction classification and ALU operation for an opcode/funct pair.
  // 'legal' is low for unsupported opcodes and unsupported funct encodings.
  function automatic dec_t decodeInstr(input logic [6:0] op, input logic [3:0] fn);
    dec_t d;
    d.cls   = C_NONE;
    d.aluOp = 4'b0000;
    d.legal = 1'b0;
    case (op)
      7'b0110011: begin
        d.cls   = C_RTYPE;
        d.legal = 1'b1;
        case (fn)
          4'b0000: d.aluOp = 4'b0010;
          4'b1000: d.aluOp = 4'b0110;
          4'b0111: d.aluOp = 4'b0000;
          4'b0110: d.aluOp = 4'b0001;
          4'b0100: d.aluOp = 4'b0011;
          default: d.legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        // fn[3] is an immediate bit for I-ALU, so only funct3 selects the op
        d.cls   = C_IALU;
        d.legal = 1'b1;
        case (fn[2:0])
          3'b000:  d.aluOp = 4'b0010;
          3'b111:  d.aluOp = 4'b0000;
          3'b110:  d.aluOp = 4'b0001;
          3'b100:  d.aluOp = 4'b0011;
          default: d.legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        d.cls   = C_LOAD;
        d.aluOp = 4'b0010;
        d.legal = 1'b1;
      end
      7'b0100011: begin
        d.cls   = C_STORE;
        d.aluOp = 4'b0010;
        d.legal = 1'b1;
      end
      7'b1100011: begin
        // only beq is supported
        d.cls   = C_BRANCH;
        d.aluOp = 4'b0110;
        d.legal = (fn[2:0] == 3'b000);
      end
      default: begin
        d.cls   = C_NONE;
        d.legal = 1'b0;
      end
    endcase
    return d;
  endfunction

  function automatic logic isLegal(input logic [6:0] op, input logic [3:0] fn);
    dec_t d;
    d = decodeInstr(op, fn);
    return d.legal;
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [3:0]  funct_q, funct_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic        illegal_q, illegal_d;

  dec_t        decLat;
  logic        inLegal;

  // Live inputs only matter for the DECODE transition; every later state
  // works from the copies latched in DECODE.
  assign inLegal = isLegal(Opcode, Funct);
  assign decLat  = decodeInstr(opcode_q, funct_q);

  // Next-state logic. The wait counter is cleared on the way into MEM and
  // advanced on each MEM cycle without mem_ready; completion is tested first
  // so a mem_ready arriving on the timeout cycle still completes the access.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    waitCnt_d = waitCnt_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        opcode_d = Opcode;
        funct_d  = Funct;
        if (inLegal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (!decLat.legal) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          case (decLat.cls)
            C_RTYPE, C_IALU: state_d = S_WB;
            C_LOAD, C_STORE: begin
              state_d   = S_MEM;
              waitCnt_d = '0;
            end
            C_BRANCH: state_d = S_FETCH;
            default: begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (decLat.cls == C_LOAD) ? S_WB : S_FETCH;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
          if (waitCnt_d == WAIT_W'(MEM_TIMEOUT)) begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      funct_q   <= '0;
      waitCnt_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      waitCnt_q <= waitCnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore strobes decoded from the state and the latched instruction. Reset
  // forces them low directly, because the reset state is FETCH, which would
  // otherwise raise IRWrite while reset is still held. The store-completion
  // PCWrite in MEM is the only strobe that looks at mem_ready.
  always_comb begin
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    Branch    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrc    = 1'b0;
    RegWrite  = 1'b0;
    Operation = 4'b0000;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          IRWrite = 1'b1;
        end
        S_EXEC: begin
          Operation = decLat.aluOp;
          ALUSrc    = (decLat.cls == C_IALU) || (decLat.cls == C_LOAD) ||
                      (decLat.cls == C_STORE);
          Branch    = (decLat.cls == C_BRANCH);
          PCWrite   = (decLat.cls == C_BRANCH);
        end
        S_MEM: begin
          Operation = decLat.aluOp;
          MemRead   = (decLat.cls == C_LOAD);
          MemWrite  = (decLat.cls == C_STORE);
          PCWrite   = (decLat.cls == C_STORE) && mem_ready;
        end
        S_WB: begin
          Operation = decLat.aluOp;
          RegWrite  = 1'b1;
          PCWrite   = 1'b1;
          MemtoReg  = (decLat.cls == C_LOAD);
        end
        default: begin
          Operation = 4'b0000;
        end
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  // One PCWrite cycle per completed instruction; TRAP never retires.
  always_comb begin
    retired_d = retired_q;
    if (PCWrite && (state_q != S_TRAP)) begin
      retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Each instruction is turned into a per-cycle
// plan of inputs and expected outputs derived from the instruction tables; the
// expectations go into a scoreboard queue that a separate monitor drains on
// every falling edge while reset is low.

module tb_multicycle_control;

   localparam int T  = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [6:0] Opcode = '0;
   logic [3:0] Funct = '0;
   logic mem_ready = 1'b0;
   logic IRWrite, PCWrite, Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite;
   logic [3:0] Operation;
   logic [2:0] state;
   logic illegal;
`ifdef CTRL_RETIRE_CNT_EN
   logic [CW-1:0] retired;
`endif

   multicycle_control #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
      .clk(clk),
      .reset(reset),
      .Opcode(Opcode),
      .Funct(Funct),
      .mem_ready(mem_ready),
      .IRWrite(IRWrite),
      .PCWrite(PCWrite),
      .Branch(Branch),
      .MemRead(MemRead),
      .MemWrite(MemWrite),
      .MemtoReg(MemtoReg),
      .ALUSrc(ALUSrc),
      .RegWrite(RegWrite),
      .Operation(Operation),
      .state(state),
`ifdef CTRL_RETIRE_CNT_EN
      .retired(retired),
`endif
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] vec;
      logic        chkOp;
      string       tag;
   } exp_t;

   exp_t expQ[$];
   logic [6:0] inOp[$];
   logic [3:0] inFn[$];
   logic       inRdy[$];

   int checks = 0;
   int errors = 0;
   int retireModel = 0;
   exp_t monE;

   // Output bundle: {state, IRWrite, PCWrite, Branch, MemRead, MemWrite,
   // MemtoReg, ALUSrc, RegWrite, Operation, illegal}
   logic [15:0] actVec;
   assign actVec = {state, IRWrite, PCWrite, Branch, MemRead, MemWrite, MemtoReg,
                    ALUSrc, RegWrite, Operation, illegal};

   function automatic logic [15:0] mk(input logic [2:0] st, input logic ir, input logic pcw,
                                      input logic br, input logic mr, input logic mw,
                                      input logic m2r, input logic src, input logic rw,
                                      input logic [3:0] op, input logic ill);
      return {st, ir, pcw, br, mr, mw, m2r, src, rw, op, ill};
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual %h required %h at %0t", tag, act, req, $time);
      end
   endtask

   // Monitor: one scoreboard entry per clock cycle outside reset.
   always @(negedge clk) begin
      if (!reset && expQ.size() > 0) begin
         monE = expQ.pop_front();
         if (monE.chkOp) checkOutput(monE.tag, actVec, monE.vec);
         else checkOutput(monE.tag, actVec & 16'hFFE1, monE.vec & 16'hFFE1);
      end
   end

   task automatic pushCycle(input logic [15:0] v, input logic chk, input string tag,
                            input logic [6:0] op, input logic [3:0] fn, input logic rdy);
      exp_t e;
      e.vec = v;
      e.chkOp = chk;
      e.tag = tag;
      expQ.push_back(e);
      inOp.push_back(op);
      inFn.push_back(fn);
      inRdy.push_back(rdy);
   endtask

   // Drives one planned cycle per clock, starting at posedge+1.
   task automatic runPlan();
      while (inOp.size() > 0) begin
         Opcode = inOp.pop_front();
         Funct = inFn.pop_front();
         mem_ready = inRdy.pop_front();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      Opcode = 7'($urandom);
      Funct = 4'($urandom);
      #1;
      checkOutput("resetOutputsZero", actVec, 16'h0000);
`ifdef CTRL_RETIRE_CNT_EN
      checkOutput("resetRetiredZero", 16'(retired), 16'h0000);
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      retireModel = 0;
   endtask

   function automatic logic [6:0] rndOp();
      return 7'($urandom);
   endfunction

   function automatic logic [3:0] rndFn();
      return 4'($urandom);
   endfunction

   // Builds the expected cycle sequence for one instruction from the opcode
   // and funct tables, then runs it. lat is the MEM cycle (1-based) on which
   // mem_ready arrives; lat > T means it never arrives in time.
   task automatic applyStimulus(input logic [6:0] op, input logic [3:0] fn, input int lat);
      int rMap[int];
      int iMap[int];
      int kind;
      logic ok;
      logic [3:0] alu;
      logic trapped;
      logic done;
      logic src;
      logic isBr;
      rMap = '{0: 2, 8: 6, 7: 0, 6: 1, 4: 3};
      iMap = '{0: 2, 7: 0, 6: 1, 4: 3};
      kind = -1;
      ok = 1'b0;
      alu = 4'd0;
      trapped = 1'b0;
      if (op == 7'b0110011) begin
         kind = 0;
         ok = rMap.exists(int'(fn));
         if (ok) alu = 4'(rMap[int'(fn)]);
      end else if (op == 7'b0010011) begin
         kind = 1;
         ok = iMap.exists(int'(fn[2:0]));
         if (ok) alu = 4'(iMap[int'(fn[2:0])]);
      end else if (op == 7'b0000011 || op == 7'b0100011) begin
         kind = (op == 7'b0000011) ? 2 : 3;
         ok = 1'b1;
         alu = 4'd2;
      end else if (op == 7'b1100011) begin
         kind = 4;
         ok = (fn[2:0] == 3'b000);
         alu = 4'd6;
      end

      pushCycle(mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0), 1, "fetch", rndOp(), rndFn(), 1'($urandom));
      pushCycle(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0), 1, "decode", op, fn, 1'($urandom));
      if (!ok) begin
         trapped = 1'b1;
      end else begin
         src = (kind == 1 || kind == 2 || kind == 3);
         isBr = (kind == 4);
         pushCycle(mk(3'd2, 0, isBr, isBr, 0, 0, 0, src, 0, alu, 0), 1, "exec",
                   rndOp(), rndFn(), 1'($urandom));
         if (kind == 0 || kind == 1) begin
            pushCycle(mk(3'd4, 0, 1, 0, 0, 0, 0, 0, 1, alu, 0), 0, "wb", rndOp(), rndFn(), 1'($urandom));
         end else if (kind == 2 || kind == 3) begin
            for (int k = 1; k <= T; k++) begin
               done = (k == lat);
               pushCycle(mk(3'd3, 0, (kind == 3) && done, 0, kind == 2, kind == 3, 0, 0, 0, alu, 0),
                         0, "mem", rndOp(), rndFn(), done);
               if (done) break;
            end
            if (lat > T) trapped = 1'b1;
            else if (kind == 2)
               pushCycle(mk(3'd4, 0, 1, 0, 0, 0, 1, 0, 1, alu, 0), 0, "wbLoad", rndOp(), rndFn(), 1'($urandom));
         end
      end
      if (trapped) begin
         // mem_ready is forced high on the first TRAP cycle; it must be ignored
         for (int k = 0; k < 3; k++)
            pushCycle(mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 1), 1, "trap", rndOp(), rndFn(),
                      (k == 0) ? 1'b1 : 1'($urandom));
      end
      runPlan();
      if (trapped) doReset();
      else retireModel++;
   endtask

   // Store caught by reset in its second MEM cycle, between clock edges.
   task automatic resetInMem();
      pushCycle(mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0), 1, "rimFetch", rndOp(), rndFn(), 1'b0);
      pushCycle(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0), 1, "rimDecode", 7'b0100011, 4'h2, 1'b0);
      pushCycle(mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 0, 4'd2, 0), 1, "rimExec", rndOp(), rndFn(), 1'b0);
      pushCycle(mk(3'd3, 0, 0, 0, 0, 1, 0, 0, 0, 4'd2, 0), 0, "rimMem", rndOp(), rndFn(), 1'b0);
      runPlan();
      #1;
      checkOutput("rimMemWriteHeld", 16'(MemWrite), 16'h0001);
      reset = 1'b1;
      #1;
      checkOutput("rimMemWriteDrop", 16'(MemWrite), 16'h0000);
      checkOutput("rimStateFetch", 16'(state), 16'h0000);
      doReset();
   endtask

   initial begin
      int pick;
      logic [6:0] ops[5];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
      #1;
      doReset();

      applyStimulus(7'b0110011, 4'b0000, 0);
      applyStimulus(7'b0000011, 4'b0010, 3);
      applyStimulus(7'b0100011, 4'b0010, 99);
      applyStimulus(7'b1111111, 4'b0000, 0);
      applyStimulus(7'b1100011, 4'b0001, 0);
      applyStimulus(7'b0100011, 4'b0010, T);
      applyStimulus(7'b1100011, 4'b1000, 0);
      applyStimulus(7'b0010011, 4'b1111, 0);
      applyStimulus(7'b0110011, 4'b0001, 0);
      applyStimulus(7'b0000011, 4'b0000, T + 1);
      resetInMem();

`ifdef CTRL_RETIRE_CNT_EN
      doReset();
      for (int i = 0; i < 17; i++) applyStimulus(ops[i % 5], 4'b0000, 1 + (i % 4));
      checkOutput("retired17", 16'(retired), 16'h0001);
`endif

      for (int i = 0; i < 200; i++) begin
         pick = $urandom_range(0, 5);
         applyStimulus((pick < 5) ? ops[pick] : rndOp(), rndFn(), $urandom_range(1, T + 2));
      end

`ifdef CTRL_RETIRE_CNT_EN
      checkOutput("retiredFinal", 16'(retired), 16'(retireModel % (1 << CW)));
`endif
      checkOutput("scoreboardDrained", 16'(expQ.size()), 16'h0000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
